// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared sizing helpers for the pipelined prefix adder.
package pipelined_prefix_adder_pkg;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0)
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of Kogge-Stone levels needed to span the full operand
    function automatic int unsigned num_levels(input int unsigned width);
        return clog2(width);
    endfunction

    // Number of prefix pipeline stages when packing lps levels per stage
    function automatic int unsigned num_stages(input int unsigned width, input int unsigned lps);
        return (num_levels(width) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/pipelined_prefix_adder_prefix_level.sv
// One combinational Kogge-Stone level combining each bit with the bit SPAN below it.
module pipelined_prefix_adder_prefix_level #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned SPAN  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    // Black cells above 2*SPAN, grey cells where the group already reaches bit 0, passthrough below SPAN
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        if (i >= int'(2 * SPAN)) begin : g_black
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i - int'(SPAN)]);
            assign p_out[i] = p_in[i] & p_in[i - int'(SPAN)];
        end else if (i >= int'(SPAN)) begin : g_grey
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i - int'(SPAN)]);
            assign p_out[i] = p_in[i];
        end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides and a collapsing-bubble pipeline.
module pipelined_prefix_adder
    import pipelined_prefix_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned LPS   = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned L = num_levels(WIDTH);
    localparam int unsigned S = num_stages(WIDTH, LPS);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    // Stage payload: running group G/P, raw per-bit propagate for the sum, carry-in, tag
    typedef struct packed {
        gp_t              gp;
        logic [WIDTH-1:0] pr;
        logic             c0;
        logic [TAG_W-1:0] tag;
    } stg_t;

    stg_t             st   [0:S-1];
    stg_t             st_d [0:S-1];
    stg_t             st0_d;
    gp_t              lvl  [1:L];
    logic [S:0]       v;
    logic [S:0]       vin;
    logic [S:0]       ld;
    logic [WIDTH-1:0] operand_b;
    logic             carry_in;
    logic [WIDTH-1:0] gfin;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;
    logic             unused_pfin;

    // Operand conditioning; carry-in is folded into the bit-0 generate so no carry fix-up is needed later
    always_comb begin
        st0_d     = '0;
        operand_b = in_sub ? ~in_b : in_b;
        carry_in  = in_sub | in_cin;
        st0_d.gp.p = in_a ^ operand_b;
        st0_d.gp.g = in_a & operand_b;
        st0_d.gp.g[0] = st0_d.gp.g[0] | (st0_d.gp.p[0] & carry_in);
        st0_d.pr  = in_a ^ operand_b;
        st0_d.c0  = carry_in;
        st0_d.tag = in_tag;
    end

    assign st_d[0] = st0_d;

    // Prefix levels; the first level of each stage reads that stage's input register
    for (genvar j = 1; j <= int'(L); j++) begin : g_lvl
        gp_t              lin;
        logic [WIDTH-1:0] gout;
        logic [WIDTH-1:0] pout;

        if (((j - 1) % int'(LPS)) == 0) begin : g_from_reg
            assign lin = st[(j - 1) / int'(LPS)].gp;
        end else begin : g_from_lvl
            assign lin = lvl[j - 1];
        end

        pipelined_prefix_adder_prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (32'd1 << (j - 1))
        ) u_level (
            .g_in  (lin.g),
            .p_in  (lin.p),
            .g_out (gout),
            .p_out (pout)
        );

        assign lvl[j] = '{g: gout, p: pout};
    end

    // Intermediate stage inputs: group G/P after this stage's levels, sideband carried along
    for (genvar k = 1; k < int'(S); k++) begin : g_stage_d
        assign st_d[k] = '{gp: lvl[k * int'(LPS)], pr: st[k-1].pr, c0: st[k-1].c0, tag: st[k-1].tag};
    end

    // Post-compute for the output register: carry into bit i is the group generate of bits below i
    always_comb begin
        gfin   = lvl[L].g;
        sum_d  = st[S-1].pr ^ {gfin[WIDTH-2:0], st[S-1].c0};
        cout_d = gfin[WIDTH-1];
        ovf_d  = gfin[WIDTH-2] ^ gfin[WIDTH-1];
        zero_d = ~|sum_d;
    end

    assign unused_pfin = &{1'b0, lvl[L].p};

    // Ready chain: a stage can load if it or any stage downstream is empty, or the consumer takes a result
    always_comb begin : ready_chain
        logic acc;
        acc = out_ready;
        ld  = '0;
        for (int i = int'(S); i >= 0; i--) begin
            acc   = acc | ~v[i];
            ld[i] = acc;
        end
    end

    assign vin       = {v[S-1:0], in_valid};
    assign in_ready  = ld[0];
    assign out_valid = v[S];

    // Pipeline registers: each stage loads on its ready, data only captured alongside a valid op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v        <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            out_tag  <= '0;
            for (int k = 0; k < int'(S); k++) begin
                st[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(S); k++) begin
                if (ld[k]) begin
                    v[k] <= vin[k];
                    if (vin[k]) begin
                        st[k] <= st_d[k];
                    end
                end
            end
            if (ld[S]) begin
                v[S] <= vin[S];
                if (vin[S]) begin
                    out_sum  <= sum_d;
                    out_cout <= cout_d;
                    out_ovf  <= ovf_d;
                    out_zero <= zero_d;
                    out_tag  <= st[S-1].tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench: directed cases plus random traffic against an arithmetic reference model.
module tb_pipelined_prefix_adder;

    localparam int unsigned WIDTH   = 30;
    localparam int unsigned LPS     = 2;
    localparam int unsigned TAG_W   = 4;
    localparam int          LEVELS  = $clog2(WIDTH);
    localparam int          LATENCY = 1 + (LEVELS + int'(LPS) - 1) / int'(LPS);
    localparam longint      MOD     = 64'sd1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   nostall = 1'b0;
    bit   last_acc;
    bit   last_emit;

    pipelined_prefix_adder #(.WIDTH(WIDTH), .LPS(LPS), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: integer A+B+cin or A-B, reduced mod 2^WIDTH; overflow from the true signed result
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub, input logic [TAG_W-1:0] tag,
                                   input int c);
        exp_t   e;
        longint ua, ub, full, sa, sb, res;
        ua = longint'(a);
        ub = longint'(b);
        if (sub) begin
            full   = ua - ub + MOD;
            e.cout = (ua >= ub);
        end else begin
            full   = ua + ub + longint'(cin);
            e.cout = (full >= MOD);
        end
        e.sum  = WIDTH'(full % MOD);
        sa     = (ua >= MOD / 2) ? ua - MOD : ua;
        sb     = (ub >= MOD / 2) ? ub - MOD : ub;
        res    = sub ? sa - sb : sa + sb + longint'(cin);
        e.ovf  = (res >= MOD / 2) || (res < -(MOD / 2));
        e.zero = (e.sum == '0);
        e.tag  = tag;
        e.cyc  = c;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        logic [WIDTH-1:0] r;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = '1;
            2:       r = WIDTH'(64'd1 << (WIDTH - 1));
            3:       r = WIDTH'((64'd1 << (WIDTH - 1)) - 1);
            default: r = WIDTH'($urandom);
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: check handshake and result against the model, then advance
    task automatic tick();
        exp_t e;
        #1;
        check("in_ready", 64'(in_ready), 64'(out_ready || (q.size() < LATENCY)));
        last_acc  = in_valid && in_ready;
        last_emit = out_valid && out_ready;
        if (out_valid) begin
            check("valid_with_op_in_flight", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q[0];
                check("result", 64'({out_sum, out_cout, out_ovf, out_zero, out_tag}),
                      64'({e.sum, e.cout, e.ovf, e.zero, e.tag}));
                if (out_ready) begin
                    if (nostall) check("latency", 64'(cyc - e.cyc), 64'(LATENCY));
                    else         check("latency_min", 64'((cyc - e.cyc) >= LATENCY), 64'd1);
                    void'(q.pop_front());
                end
            end
        end
        if (last_acc) q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag, cyc));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic sub, input logic [TAG_W-1:0] tag);
        int tries;
        tries    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_tag   = tag;
        do begin
            tick();
            tries++;
        end while (!last_acc && tries < 64);
        if (!last_acc) check("send_timeout", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect_now(input string tag, input logic [WIDTH-1:0] s, input logic co,
                              input logic ov, input logic z, input logic [TAG_W-1:0] t);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check(tag, 64'({out_sum, out_cout, out_ovf, out_zero, out_tag}), 64'({s, co, ov, z, t}));
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int idx;
        int emitted;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_sub = 1'b0; in_tag = '0; out_ready = 1'b0;
        #2;
        check("reset_outputs", 64'({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Longest carry chain: all-ones + 0 + cin
        nostall   = 1'b1;
        out_ready = 1'b1;
        send(30'h3FFF_FFFF, 30'h0, 1'b1, 1'b0, 4'd3);
        repeat (LATENCY - 1) tick();
        expect_now("max_carry", 30'h0, 1'b1, 1'b0, 1'b1, 4'd3);
        tick();

        // Positive signed overflow
        send(30'h1FFF_FFFF, 30'h1, 1'b0, 1'b0, 4'd1);
        repeat (LATENCY - 1) tick();
        expect_now("signed_ovf", 30'h2000_0000, 1'b0, 1'b1, 1'b0, 4'd1);
        tick();

        // Subtraction with borrow; cin must be ignored
        send(30'd5, 30'd7, 1'b1, 1'b1, 4'd7);
        repeat (LATENCY - 1) tick();
        expect_now("sub_borrow", 30'h3FFF_FFFE, 1'b0, 1'b0, 1'b0, 4'd7);
        tick();

        send(30'd7, 30'd5, 1'b0, 1'b1, 4'd9);
        repeat (LATENCY - 1) tick();
        expect_now("sub_no_borrow", 30'd2, 1'b1, 1'b0, 1'b0, 4'd9);
        tick();

        // Back-to-back throughput with exact latency
        for (int i = 0; i < 5; i++) send(pick(), pick(), 1'($urandom), 1'($urandom), 4'(i + 10));
        drain();

        // Backpressure: pipeline fills to LATENCY then stalls the producer
        nostall   = 1'b0;
        out_ready = 1'b0;
        idx       = 0;
        repeat (8) begin
            in_valid = (idx < 6);
            in_a = pick(); in_b = pick(); in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_tag = 4'(idx);
            tick();
            if (last_acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'(LATENCY));
        out_ready = 1'b1;
        emitted   = 0;
        repeat (6) begin
            in_valid = (idx < 6);
            in_a = pick(); in_b = pick(); in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_tag = 4'(idx);
            tick();
            if (last_acc) idx++;
            if (last_emit) emitted++;
        end
        check("bp_all_accepted", 64'(idx), 64'd6);
        check("bp_stream_one_per_cycle", 64'(emitted), 64'd6);
        drain();

        // Asynchronous reset with ops in flight
        out_ready = 1'b0;
        for (int i = 0; i < LATENCY; i++) send(pick(), pick(), 1'b0, 1'b0, 4'(i + 1));
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midflight_reset_outputs",
              64'({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag}), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_midflight_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();

        // Random traffic with random stalls on both sides
        nostall = 1'b0;
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_a = pick(); in_b = pick(); in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_tag = 4'($urandom);
            tick();
        end
        drain();

        // Random traffic with the consumer always ready: latency must be exact
        nostall   = 1'b1;
        out_ready = 1'b1;
        repeat (500) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = pick(); in_b = pick(); in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_tag = 4'($urandom);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
